fl_ckpt: RTL
============

// Module: fl_ckpt
// PURPOSE
//  Multi-port physical-register free list with branch checkpoints. It is the rename-stage successor to the basic FL.
//  Hands out up to ALLOC_W free phy regs per cycle, all-or-nothing. Accepts up to FREE_W freed regs per cycle.
//  Snapshots the allocation pointer per in-flight branch. On mispredict it restores that pointer in one cycle.
//  Sits between rename (alloc), retire/rewind (free) and the branch stack (ckpt take/restore).
// PARAMETERS
//  SIZE      64  entries; power of 2, >= ALLOC_W
//  PHY_BITS  7   width of a phy reg tag
//  ALLOC_W   2   allocation lanes per cycle
//  FREE_W    2   free lanes per cycle (retire + rewind merged upstream)
//  NUM_CKPT  4   checkpoint slots
//  INIT_BASE 32  tag held in entry 0 at reset; entry i holds INIT_BASE+i
// PORTS
//  clock         in   1                   clock
//  reset         in   1                   synchronous, active-high
//  alloc_req     in   ALLOC_W             per-lane request; lanes need not be contiguous
//  alloc_ready   out  1                   count >= popcount(alloc_req) and no restore this cycle
//  alloc_phy     out  ALLOC_W*PHY_BITS    granted tag per requesting lane; 0 on non-requesting lanes
//  free_valid    in   FREE_W              per-lane free strobe
//  free_phy      in   FREE_W*PHY_BITS     tag to return, lane i
//  ckpt_take     in   1                   snapshot head into slot ckpt_id
//  ckpt_id       in   clog2(NUM_CKPT)     slot written by ckpt_take
//  ckpt_restore  in   1                   rewind head to slot restore_id
//  restore_id    in   clog2(NUM_CKPT)     slot read by ckpt_restore
//  count         out  clog2(SIZE)+1       registered number of free entries
//  err           out  1                   sticky error flag; cleared only by reset
// BEHAVIOUR
//  State
//   - data[SIZE] holds the tags.
//   - head and tail are clog2(SIZE)+1 bits wide. The MSB is a wrap bit.
//   - count = tail - head, modulo 2^(clog2(SIZE)+1). This separates full from empty without a flag.
//   - ckpt_head[NUM_CKPT] and ckpt_vld[NUM_CKPT].
//  Reset
//   - data[i] = INIT_BASE+i; head = 0; tail = SIZE (list full, count = SIZE).
//   - ckpt_vld = 0; err = 0; alloc_phy = 0; alloc_ready = 1.
//  Allocation (combinational grant, committed at the clock edge)
//   - Let k = number of requesting lanes below lane i. Lane i gets alloc_phy[i] = data[(head+k) % SIZE].
//   - Grant happens only when alloc_ready = 1. Then head_next = head + popcount(alloc_req).
//   - When alloc_ready = 0, head is unchanged and nothing is granted. Rename must stall.
//   - alloc_ready uses the registered count only. Same-cycle frees are NOT bypassed; they are visible next cycle.
//  Free
//   - Each valid lane, in lane order, writes data[tail % SIZE] = free_phy[i] and increments tail.
//   - A free while the running count == SIZE is dropped and sets err.
//  Checkpoint take
//   - ckpt_head[ckpt_id] = head_next, i.e. after this cycle's allocation; ckpt_vld[ckpt_id] = 1.
//   - Retaking a valid slot overwrites it silently.
//  Restore
//   - If ckpt_vld[restore_id]: head_next = ckpt_head[restore_id]; all slots are invalidated.
//   - alloc_ready is forced to 0 that cycle.
//   - Frees in the same cycle still append at tail.
//   - Restore of an invalid slot: no-op, sets err.
//  Priority within a cycle
//   - restore > alloc for head.
//   - Frees always apply to tail.
//   - If ckpt_take and ckpt_restore are both asserted, restore wins and the take is dropped.
//  Wrap-around
//   - Pointer arithmetic wraps naturally. Data index = pointer[clog2(SIZE)-1:0].
//  All outputs except alloc_phy and alloc_ready are registered.
// TESTING
//  - Reset, then alloc_req = 2'b11 -> alloc_phy = {33, 32}, ready = 1; next cycle count = 62.
//  - alloc_req = 2'b10 after reset -> lane1 = 32, lane0 = 0; count = 63.
//  - Drain to count = 1, then alloc_req = 2'b11 -> ready = 0, head holds; free 1 tag -> ready = 1 the cycle after.
//  - ckpt_take id=1 at count 60, alloc 4 more, then restore id=1 -> count = 60; next grants replay the same tags.
//  - Restore plus 2 frees in one cycle -> count = ckpt count + 2; ready = 0 that cycle; err = 0.
//  - Free at count = 64 -> dropped, err = 1; restore of an invalid slot -> err = 1, head unchanged.
//  - Run 200 cycles of random alloc/free across the wrap -> every tag is unique; tags allocated + free == SIZE.

Source files
------------

// File: rtl/fl_ckpt.sv
// Multi-port physical-register free list with branch checkpoints.
// Circular tag buffer with wrap-bit pointers; head snapshots allow a one-cycle rewind on mispredict.
module fl_ckpt #(
  parameter int SIZE      = 64,
  parameter int PHY_BITS  = 7,
  parameter int ALLOC_W   = 2,
  parameter int FREE_W    = 2,
  parameter int NUM_CKPT  = 4,
  parameter int INIT_BASE = 32,
  localparam int IDX_W    = $clog2(SIZE),
  localparam int PTR_W    = $clog2(SIZE) + 1,
  localparam int CKPT_W   = $clog2(NUM_CKPT)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [ALLOC_W-1:0]          alloc_req,
  output logic                        alloc_ready,
  output logic [ALLOC_W*PHY_BITS-1:0] alloc_phy,
  input  logic [FREE_W-1:0]           free_valid,
  input  logic [FREE_W*PHY_BITS-1:0]  free_phy,
  input  logic                        ckpt_take,
  input  logic [CKPT_W-1:0]           ckpt_id,
  input  logic                        ckpt_restore,
  input  logic [CKPT_W-1:0]           restore_id,
  output logic [PTR_W-1:0]            count,
  output logic                        err
);

  logic [PHY_BITS-1:0] data_q [SIZE];
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [PTR_W-1:0]    ckpt_head_q [NUM_CKPT];
  logic [NUM_CKPT-1:0] ckpt_vld_q;
  logic                err_q, err_d;

  logic [PTR_W-1:0]    alloc_cnt;
  logic [PTR_W-1:0]    offs;
  logic [IDX_W-1:0]    rd_idx;
  logic [PTR_W-1:0]    run_cnt;
  logic [FREE_W-1:0]   free_we;
  logic [IDX_W-1:0]    free_addr [FREE_W];
  logic                err_free;
  logic                restore_ok;
  logic                err_restore;
  logic                take_en;

  // count is derived purely from registered pointers, so it is a registered output.
  assign count = tail_q - head_q;
  assign err   = err_q;

  always_comb begin
    alloc_cnt = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      if (alloc_req[i]) alloc_cnt = alloc_cnt + PTR_W'(1);
    end
  end

  // Same-cycle frees are deliberately not bypassed into readiness.
  assign alloc_ready = (count >= alloc_cnt) && !ckpt_restore;

  // Lane i reads the entry offset by the number of requesting lanes below it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    alloc_phy = '0;
    offs      = '0;
    rd_idx    = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      if (alloc_req[i]) begin
        rd_idx = IDX_W'(head_q + offs);
        if (alloc_ready) alloc_phy[i*PHY_BITS +: PHY_BITS] = data_q[rd_idx];
        offs = offs + PTR_W'(1);
      end
    end
  end

  // Frees are applied in lane order; the running count guards overflow lane by lane.
  always_comb begin
    // NOTE: blocking assignments here model the lane-by-lane running values; state regs use <= only.
    tail_d    = tail_q;
    run_cnt   = count;
    err_free  = 1'b0;
    free_we   = '0;
    free_addr = '{default: '0};
    for (int i = 0; i < FREE_W; i++) begin
      free_addr[i] = tail_d[IDX_W-1:0];
      if (free_valid[i]) begin
        if (run_cnt == PTR_W'(SIZE)) begin
          err_free = 1'b1;
        end else begin
          free_we[i] = 1'b1;
          tail_d     = tail_d + PTR_W'(1);
          run_cnt    = run_cnt + PTR_W'(1);
        end
      end
    end
  end

  always_comb begin
    restore_ok  = ckpt_restore && ckpt_vld_q[restore_id];
    err_restore = ckpt_restore && !ckpt_vld_q[restore_id];
    take_en     = ckpt_take && !ckpt_restore;
    head_d      = head_q;
    if (restore_ok) begin
      head_d = ckpt_head_q[restore_id];
    end else if (alloc_ready) begin
      head_d = head_q + alloc_cnt;
    end
    err_d = err_q | err_free | err_restore;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= PTR_W'(SIZE);
      ckpt_vld_q <= '0;
      err_q      <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      err_q  <= err_d;
      if (restore_ok) begin
        ckpt_vld_q <= '0;
      end else if (take_en) begin
        ckpt_vld_q[ckpt_id] <= 1'b1;
      end
    end
  end

  // Snapshot values are only ever read behind a valid bit, so they carry no reset.
  always_ff @(posedge clock) begin
    if (take_en) ckpt_head_q[ckpt_id] <= head_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: this array is reset on purpose: the list must come up holding the initial tag set.
      for (int i = 0; i < SIZE; i++) data_q[i] <= PHY_BITS'(INIT_BASE + i);
    end else begin
      for (int i = 0; i < FREE_W; i++) begin
        if (free_we[i]) data_q[free_addr[i]] <= free_phy[i*PHY_BITS +: PHY_BITS];
      end
    end
  end

endmodule
